// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit:
// opcodes, FSM states, ALU op classes and datapath mux selects.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef logic [3:0] state_t;

    localparam state_t S_FETCH    = 4'd0;
    localparam state_t S_DECODE   = 4'd1;
    localparam state_t S_MEMADR   = 4'd2;
    localparam state_t S_MEMREAD  = 4'd3;
    localparam state_t S_MEMWB    = 4'd4;
    localparam state_t S_MEMWRITE = 4'd5;
    localparam state_t S_EXECR    = 4'd6;
    localparam state_t S_EXECI    = 4'd7;
    localparam state_t S_ALUWB    = 4'd8;
    localparam state_t S_BRANCH   = 4'd9;
    localparam state_t S_JAL      = 4'd10;
    localparam state_t S_TRAP     = 4'd11;

    typedef enum logic [1:0] {
        ALUOP_ADD  = 2'b00,
        ALUOP_SUB  = 2'b01,
        ALUOP_FUNC = 2'b10
    } aluop_e;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_A     = 2'b10;

    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic [1:0] imm_src(input logic [6:0] op);
        logic [1:0] s;
        s = IMM_I;
        unique case (1'b1)
            op == OP_STORE:  s = IMM_S;
            op == OP_BRANCH: s = IMM_B;
            op == OP_JAL:    s = IMM_J;
            default:         s = IMM_I;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/multicycle_control_unit_alu_decoder.sv
// ALU control decode: ALUOp class plus funct fields -> ALUControl,
// and a flag for funct encodings this core does not implement.
module mc_alu_decoder
    import riscv_ctrl_pkg::*;
#(
    parameter int ALUCTRL_W = 3
) (
    input  aluop_e               aluop,
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic [6:0]           funct7,
    output logic [ALUCTRL_W-1:0] alu_control,
    output logic                 bad_funct
);

    logic [2:0] ctrl;
    logic       is_r;
    logic       is_i;

    assign is_r = (op == OP_R);
    assign is_i = (op == OP_I);

    always_comb begin
        ctrl = ALU_ADD;
        unique case (aluop)
            ALUOP_SUB: ctrl = ALU_SUB;
            ALUOP_FUNC: begin
                unique case (1'b1)
                    funct3 == 3'b000:
                        ctrl = (op[5] & funct7[5]) ? ALU_SUB : ALU_ADD;
                    funct3 == 3'b010: ctrl = ALU_SLT;
                    funct3 == 3'b110: ctrl = ALU_OR;
                    funct3 == 3'b111: ctrl = ALU_AND;
                    default:          ctrl = ALU_ADD;
                endcase
            end
            default: ctrl = ALU_ADD;
        endcase
    end

    always_comb begin
        bad_funct = 1'b0;
        if (is_r || is_i) begin
            unique case (funct3)
                3'b000, 3'b010, 3'b110, 3'b111: bad_funct = 1'b0;
                default:                        bad_funct = 1'b1;
            endcase
        end
        // Only the add/sub distinction lives in funct7 here
        if (is_r && funct7 != 7'b0000000 && funct7 != 7'b0100000)
            bad_funct = 1'b1;
    end

    assign alu_control = ALUCTRL_W'(ctrl);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM with memory-ready stalls,
// optional BNE and a sticky illegal-instruction trap.
module multicycle_control_unit
    import riscv_ctrl_pkg::*;
#(
    parameter bit USE_MEM_READY = 1'b1,
    parameter bit SUPPORT_BNE   = 1'b1,
    parameter int ALUCTRL_W     = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           Op,
    input  logic [2:0]           funct3,
    input  logic [6:0]           funct7,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 PCWrite,
    output logic                 AdrSrc,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ImmSrc,
    output logic                 RegWrite,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic                 instr_done,
    output logic                 illegal
);

    state_t state;
    state_t next;
    logic   ill_q;
    logic   ready;
    logic   is_bne;
    logic   branch_ok;
    logic   bad_funct;
    aluop_e aluop;

    assign ready     = USE_MEM_READY ? mem_ready : 1'b1;
    assign is_bne    = SUPPORT_BNE && (funct3 == 3'b001);
    assign branch_ok = (funct3 == 3'b000) || is_bne;

    mc_alu_decoder #(
        .ALUCTRL_W(ALUCTRL_W)
    ) u_alu_dec (
        .aluop      (aluop),
        .op         (Op),
        .funct3     (funct3),
        .funct7     (funct7),
        .alu_control(ALUControl),
        .bad_funct  (bad_funct)
    );

    always_comb begin
        next = state;
        unique case (state)
            S_FETCH:  if (ready) next = S_DECODE;
            S_DECODE: begin
                unique case (1'b1)
                    Op == OP_LOAD || Op == OP_STORE:
                        next = S_MEMADR;
                    Op == OP_R:
                        next = bad_funct ? S_TRAP : S_EXECR;
                    Op == OP_I:
                        next = bad_funct ? S_TRAP : S_EXECI;
                    Op == OP_BRANCH:
                        next = branch_ok ? S_BRANCH : S_TRAP;
                    Op == OP_JAL:
                        next = S_JAL;
                    default:
                        next = S_TRAP;
                endcase
            end
            S_MEMADR:
                next = (Op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (ready) next = S_MEMWB;
            S_MEMWB:    next = S_FETCH;
            S_MEMWRITE: if (ready) next = S_FETCH;
            S_EXECR:    next = S_ALUWB;
            S_EXECI:    next = S_ALUWB;
            S_ALUWB:    next = S_FETCH;
            S_BRANCH:   next = S_FETCH;
            S_JAL:      next = S_ALUWB;
            S_TRAP:     next = S_TRAP;
            default:    next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
            ill_q <= 1'b0;
        end else begin
            state <= next;
            ill_q <= ill_q | (next == S_TRAP);
        end
    end

    // Enables are suppressed while rst is high so no store or
    // register write can escape in the reset cycle.
    always_comb begin
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        instr_done = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_B;
        aluop      = ALUOP_ADD;
        if (!rst) begin
            unique case (state)
                S_FETCH: begin
                    IRWrite   = ready;
                    PCWrite   = ready;
                    ALUSrcB   = SRCB_FOUR;
                    ResultSrc = RES_ALURES;
                end
                S_DECODE: begin
                    ALUSrcA = SRCA_OLDPC;
                    ALUSrcB = SRCB_IMM;
                end
                S_MEMADR: begin
                    ALUSrcA = SRCA_A;
                    ALUSrcB = SRCB_IMM;
                end
                S_MEMREAD: AdrSrc = 1'b1;
                S_MEMWB: begin
                    ResultSrc  = RES_DATA;
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEMWRITE: begin
                    AdrSrc     = 1'b1;
                    MemWrite   = 1'b1;
                    instr_done = ready;
                end
                S_EXECR: begin
                    ALUSrcA = SRCA_A;
                    ALUSrcB = SRCB_B;
                    aluop   = ALUOP_FUNC;
                end
                S_EXECI: begin
                    ALUSrcA = SRCA_A;
                    ALUSrcB = SRCB_IMM;
                    aluop   = ALUOP_FUNC;
                end
                S_ALUWB: begin
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA    = SRCA_A;
                    ALUSrcB    = SRCB_B;
                    aluop      = ALUOP_SUB;
                    PCWrite    = is_bne ? ~zero : zero;
                    instr_done = 1'b1;
                end
                S_JAL: begin
                    ALUSrcA = SRCA_OLDPC;
                    ALUSrcB = SRCB_FOUR;
                    PCWrite = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign ImmSrc  = imm_src(Op);
    assign illegal = ill_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed per-cycle control-word checks for multicycle_control_unit,
// with a second instance built without BNE support.
module tb_multicycle_control_unit;

    localparam int S_RST      = 0;
    localparam int S_FETCH    = 1;
    localparam int S_DECODE   = 2;
    localparam int S_MEMADR   = 3;
    localparam int S_MEMREAD  = 4;
    localparam int S_MEMWB    = 5;
    localparam int S_MEMWRITE = 6;
    localparam int S_EXECR    = 7;
    localparam int S_EXECI    = 8;
    localparam int S_ALUWB    = 9;
    localparam int S_BRANCH   = 10;
    localparam int S_JAL      = 11;
    localparam int S_TRAP     = 12;

    localparam logic [6:0] T_LW  = 7'b0000011;
    localparam logic [6:0] T_SW  = 7'b0100011;
    localparam logic [6:0] T_R   = 7'b0110011;
    localparam logic [6:0] T_I   = 7'b0010011;
    localparam logic [6:0] T_BR  = 7'b1100011;
    localparam logic [6:0] T_JAL = 7'b1101111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] Op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic [6:0] funct7 = 7'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;

    logic       pcw, adr, mw, irw, rw, dn, ill;
    logic [1:0] res, sa, sb, imm;
    logic [2:0] ac;
    logic       pcw2, adr2, mw2, irw2, rw2, dn2, ill2;
    logic [1:0] res2, sa2, sb2, imm2;
    logic [2:0] ac2;

    multicycle_control_unit dut (
        .clk(clk), .rst(rst), .Op(Op), .funct3(funct3),
        .funct7(funct7), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(pcw), .AdrSrc(adr), .MemWrite(mw),
        .IRWrite(irw), .ResultSrc(res), .ALUSrcA(sa),
        .ALUSrcB(sb), .ImmSrc(imm), .RegWrite(rw),
        .ALUControl(ac), .instr_done(dn), .illegal(ill)
    );

    multicycle_control_unit #(.SUPPORT_BNE(1'b0)) u_nb (
        .clk(clk), .rst(rst), .Op(Op), .funct3(funct3),
        .funct7(funct7), .zero(zero), .mem_ready(mem_ready),
        .PCWrite(pcw2), .AdrSrc(adr2), .MemWrite(mw2),
        .IRWrite(irw2), .ResultSrc(res2), .ALUSrcA(sa2),
        .ALUSrcB(sb2), .ImmSrc(imm2), .RegWrite(rw2),
        .ALUControl(ac2), .instr_done(dn2), .illegal(ill2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [17:0] w;
        logic [17:0] w2;
        int          n;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   vec = 0;

    logic [6:0] cur_op = 7'd0;
    logic [2:0] cur_f3 = 3'd0;
    logic [6:0] cur_f7 = 7'd0;
    logic       ei = 1'b0;
    logic       ei2 = 1'b0;

    // Control word per state, as laid out in the state table
    function automatic logic [17:0] model(input int st, input logic m,
                                          input logic z,
                                          input logic [2:0] alu,
                                          input logic il);
        logic p, a, w, i, r, d;
        logic [1:0] rs, xa, xb, im;
        logic [2:0] c;
        {p, a, w, i, r, d} = 6'b0;
        {rs, xa, xb} = 6'b0;
        c = 3'b000;
        case (cur_op)
            T_SW:    im = 2'b01;
            T_BR:    im = 2'b10;
            T_JAL:   im = 2'b11;
            default: im = 2'b00;
        endcase
        case (st)
            S_FETCH:    begin p = m; i = m; xb = 2'b10; rs = 2'b10; end
            S_DECODE:   begin xa = 2'b01; xb = 2'b01; end
            S_MEMADR:   begin xa = 2'b10; xb = 2'b01; end
            S_MEMREAD:  a = 1'b1;
            S_MEMWB:    begin rs = 2'b01; r = 1'b1; d = 1'b1; end
            S_MEMWRITE: begin a = 1'b1; w = 1'b1; d = m; end
            S_EXECR:    begin xa = 2'b10; c = alu; end
            S_EXECI:    begin xa = 2'b10; xb = 2'b01; c = alu; end
            S_ALUWB:    begin r = 1'b1; d = 1'b1; end
            S_BRANCH: begin
                xa = 2'b10; c = 3'b001; d = 1'b1;
                p = cur_f3[0] ? ~z : z;
            end
            S_JAL:      begin xa = 2'b01; xb = 2'b10; p = 1'b1; end
            default:    ;
        endcase
        return {p, a, w, i, rs, xa, xb, im, r, c, d, il};
    endfunction

    task automatic ins(input logic [6:0] o, input logic [2:0] f3,
                       input logic [6:0] f7);
        cur_op = o;
        cur_f3 = f3;
        cur_f7 = f7;
    endtask

    task automatic step(input int st, input logic m = 1'b1,
                        input logic z = 1'b0,
                        input logic [2:0] alu = 3'b000);
        exp_t e;
        int   st2;
        @(posedge clk);
        #1;
        rst       = (st == S_RST);
        Op        = cur_op;
        funct3    = cur_f3;
        funct7    = cur_f7;
        zero      = z;
        mem_ready = m;
        st2  = (ei2 && st != S_RST) ? S_TRAP : st;
        e.w  = model(st, m, z, alu, ei);
        e.w2 = model(st2, m, z, alu, ei2);
        e.n  = vec;
        vec++;
        q.push_back(e);
    endtask

    task automatic run4(input int s3, input logic [2:0] alu);
        step(S_FETCH);
        step(S_DECODE);
        step(s3, 1'b1, 1'b0, alu);
        step(S_ALUWB);
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        logic [17:0] act;
        logic [17:0] act2;
        if (q.size() > 0) begin
            e = q.pop_front();
            act  = {pcw, adr, mw, irw, res, sa, sb, imm,
                    rw, ac, dn, ill};
            act2 = {pcw2, adr2, mw2, irw2, res2, sa2, sb2, imm2,
                    rw2, ac2, dn2, ill2};
            checks++;
            if (act !== e.w) begin
                errors++;
                $display("FAIL ctrl vec %0d: got %b want %b",
                         e.n, act, e.w);
            end
            checks++;
            if (act2 !== e.w2) begin
                errors++;
                $display("FAIL nobne vec %0d: got %b want %b",
                         e.n, act2, e.w2);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        step(S_RST);
        ins(T_R, 3'b000, 7'b0000000);  run4(S_EXECR, 3'b000);
        ins(T_R, 3'b000, 7'b0100000);  run4(S_EXECR, 3'b001);
        ins(T_I, 3'b000, 7'b0100000);  run4(S_EXECI, 3'b000);
        ins(T_R, 3'b110, 7'b0000000);  run4(S_EXECR, 3'b011);
        ins(T_I, 3'b010, 7'b0000000);  run4(S_EXECI, 3'b101);
        ins(T_I, 3'b111, 7'b0000000);  run4(S_EXECI, 3'b010);

        ins(T_LW, 3'b010, 7'd0);
        step(S_FETCH);
        step(S_DECODE);
        step(S_MEMADR);
        step(S_MEMREAD, 1'b0);
        step(S_MEMREAD, 1'b0);
        step(S_MEMREAD, 1'b1);
        step(S_MEMWB);

        ins(T_SW, 3'b010, 7'd0);
        step(S_FETCH, 1'b0);
        step(S_FETCH, 1'b0);
        step(S_FETCH, 1'b0);
        step(S_FETCH);
        step(S_DECODE);
        step(S_MEMADR);
        step(S_MEMWRITE);

        ins(T_BR, 3'b000, 7'd0);
        step(S_FETCH); step(S_DECODE); step(S_BRANCH, 1'b1, 1'b1);
        step(S_FETCH); step(S_DECODE); step(S_BRANCH, 1'b1, 1'b0);

        ins(T_BR, 3'b001, 7'd0);
        step(S_FETCH); step(S_DECODE);
        ei2 = 1'b1;
        step(S_BRANCH, 1'b1, 1'b1);
        step(S_FETCH); step(S_DECODE); step(S_BRANCH, 1'b1, 1'b0);

        ins(T_JAL, 3'b000, 7'd0);      run4(S_JAL, 3'b000);

        ins(7'b1111111, 3'b000, 7'd0);
        step(S_FETCH);
        step(S_DECODE);
        ei = 1'b1;
        for (int i = 0; i < 10; i++) step(S_TRAP);
        step(S_RST);
        ei  = 1'b0;
        ei2 = 1'b0;

        ins(T_R, 3'b000, 7'b0000001);
        step(S_FETCH);
        step(S_DECODE);
        ei  = 1'b1;
        ei2 = 1'b1;
        step(S_TRAP);
        step(S_TRAP);
        step(S_RST);
        ei  = 1'b0;
        ei2 = 1'b0;

        ins(T_SW, 3'b010, 7'd0);
        step(S_FETCH);
        step(S_DECODE);
        step(S_MEMADR);
        step(S_MEMWRITE, 1'b0);
        step(S_RST, 1'b0);

        ins(T_R, 3'b000, 7'b0000000);  run4(S_EXECR, 3'b000);

        for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multi-cycle RV32I control FSM. Successor to the single-cycle combinational control unit.
- Drives a shared-memory datapath with these registers: PC, OldPC, IR, Data, A/B, ALUOut.
- Sequences fetch, decode, execute, memory and writeback over 3-5 cycles per instruction.
- Adds three things the single-cycle unit lacks: a memory-ready stall handshake, optional BNE, and a sticky illegal-instruction trap.

Parameters:
- USE_MEM_READY, 1: 1 = FETCH/MEMREAD/MEMWRITE wait for mem_ready; 0 = mem_ready is ignored and treated as 1.
- SUPPORT_BNE, 1: 1 = funct3 001 on a branch opcode decodes as BNE; 0 = it is illegal.
- ALUCTRL_W, 3: width of ALUControl.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- Op  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7  in  7  IR[31:25]
- zero  in  1  ALU zero flag, same cycle
- mem_ready  in  1  memory completes the access this cycle
- PCWrite  out  1  PC load enable
- AdrSrc  out  1  0 = PC, 1 = ALUOut
- MemWrite  out  1  store strobe
- IRWrite  out  1  IR/OldPC load enable
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 A
- ALUSrcB  out  2  00 B, 01 ImmExt, 10 constant 4
- ImmSrc  out  2  00 I, 01 S, 10 B, 11 J (combinational from Op)
- RegWrite  out  1  register file write enable
- ALUControl  out  ALUCTRL_W  000 add, 001 sub, 010 and, 011 or, 101 slt
- instr_done  out  1  one-cycle pulse on an instruction's final cycle
- illegal  out  1  sticky trap flag

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, TRAP.
- Reset: state = FETCH; illegal = 0. Enables are Moore and decoded from state. ALUControl, ImmSrc and the PCWrite branch term are combinational.
- All enables default to 0. Selects default to 00.
- FETCH:
  - Drives AdrSrc=0, IRWrite=1, SrcA=00, SrcB=10, ResultSrc=10, ALUOp=add.
  - PCWrite and IRWrite are gated by mem_ready. The FSM stays in FETCH while mem_ready=0, so PC and IR are unchanged during a stall.
- DECODE:
  - Drives SrcA=01, SrcB=01, add (computes the branch target).
  - Next state by Op:
    - 0000011 -> MEMADR
    - 0100011 -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1100011 -> BRANCH
    - 1101111 -> JAL
    - anything else -> TRAP
  - Also -> TRAP for: branch funct3 not in {000, 001 if SUPPORT_BNE}; R-type funct7 not in {0000000, 0100000}.
- MEMADR: SrcA=10, SrcB=01, add. Next: lw -> MEMREAD, sw -> MEMWRITE.
- MEMREAD: AdrSrc=1. Hold until mem_ready, then -> MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, instr_done=1. Next -> FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1 held until mem_ready. On mem_ready: instr_done=1, -> FETCH.
- EXECR: SrcA=10, SrcB=00, ALUOp=func. Next -> ALUWB.
- EXECI: SrcA=10, SrcB=01, ALUOp=func. Next -> ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, instr_done=1. Next -> FETCH.
- BRANCH:
  - SrcA=10, SrcB=00, sub, ResultSrc=00.
  - PCWrite = zero for BEQ; PCWrite = ~zero for BNE.
  - instr_done=1. Next -> FETCH.
- JAL: SrcA=01, SrcB=10, add, ResultSrc=00, PCWrite=1. Next -> ALUWB (writes rd = PC+4).
- ALU decode (ALUOp=func):
  - funct3 000: sub only if Op[5]=1 and funct7[5]=1, else add.
  - 010 -> slt; 110 -> or; 111 -> and.
  - Other funct3 -> TRAP, checked in DECODE.
- TRAP: illegal=1, all enables 0, the FSM stays in TRAP until rst.
- mem_ready is don't-care outside FETCH, MEMREAD and MEMWRITE.
- rst asserted in any state (including mid-stall): next cycle is FETCH with every enable 0, and no MemWrite or RegWrite is issued in the reset cycle.
- Latency in cycles, zero wait states: lw 5; sw 4; R/I 4; branch 3; jal 4. Each memory wait cycle adds 1.

Decomposition:
- Shared package riscv_ctrl_pkg holds:
  - opcode constants
  - state enum
  - ALUOp and ALUControl encodings
  - ResultSrc, ALUSrcA and ALUSrcB encodings
  - ImmSrc encoding
- One sub-module, mc_alu_decoder: combinational ALUOp/funct3/funct7/Op -> ALUControl plus an illegal-funct flag.
- The FSM is the top level.

Test Plan:
- R-type add (Op 0110011, f3 000, f7 0000000, mem_ready=1):
  - States FETCH, DECODE, EXECR, ALUWB.
  - RegWrite=1 only in cycle 4; ALUControl=000 in EXECR; instr_done pulses once.
- sub (f7 0100000): ALUControl=001 in EXECR.
- addi with f7 bits 0100000: ALUControl stays 000.
- lw (0000011) with mem_ready low for 2 cycles in MEMREAD:
  - 7 cycles total; AdrSrc=1 for 3 cycles.
  - RegWrite with ResultSrc=01 in the last cycle only.
- sw (0100011):
  - MemWrite=1 in cycle 4 only; RegWrite never asserted.
  - FETCH with mem_ready=0 for 3 cycles holds PCWrite=0 and IRWrite=0.
- beq (1100011, f3 000):
  - zero=1 -> PCWrite=1 in BRANCH.
  - zero=0 -> PCWrite=0.
  - bne (f3 001): inverse result with SUPPORT_BNE=1; TRAP with SUPPORT_BNE=0.
- Op 1111111 -> TRAP after DECODE; illegal=1 held for 10 cycles; rst -> illegal=0, state FETCH.
- rst asserted mid-MEMWRITE -> MemWrite=0 next cycle, FSM in FETCH.
